// File: rtl/pkt_rcv.sv
// Serial packet receiver: synchronizes sclk/load/sdi into clk, shifts a 16-bit
// frame MSB first and reports good (pvld) or malformed (err) frames on load rise.
//   state | meaning
//   IDL   | waiting for a load falling edge; sclk ignored
//   SHF   | shifting bits on sclk rising edges until load rises
module pkt_rcv #(
  parameter int SYNC_N = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        load,
  input  logic        sdi,
  output logic [15:0] pkt,
  output logic        pvld,
  output logic        err,
  output logic        busy,
  output logic [7:0]  pcnt
);

  typedef enum logic {IDL = 1'b0, SHF = 1'b1} state_t;

  localparam logic [2:0] FLUSH_N = 3'(SYNC_N);
  localparam logic [4:0] CNT_MAX = 5'd17;
  localparam logic [4:0] CNT_PKT = 5'd16;

  state_t state, state_n;

  logic [SYNC_N-1:0] sclk_sync, load_sync, sdi_sync;
  logic              sclk_d, load_d;
  logic              sclk_s, load_s, sdi_s;
  logic [2:0]        flush_cnt;
  logic              armed;
  logic              sclk_rise, load_rise, load_fall;
  logic              enter_shf, latch, shift_en;
  logic [15:0]       shreg, sh_nxt;
  logic [4:0]        cnt, cnt_nxt;

  assign sclk_s = sclk_sync[SYNC_N-1];
  assign load_s = load_sync[SYNC_N-1];
  assign sdi_s  = sdi_sync[SYNC_N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      load_sync <= '1;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      load_d    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_N-2:0], sclk};
      load_sync <= {load_sync[SYNC_N-2:0], load};
      sdi_sync  <= {sdi_sync[SYNC_N-2:0], sdi};
      sclk_d    <= sclk_s;
      load_d    <= load_s;
    end
  end

  // The load chain resets high, so a low load at reset release would look like
  // a fall; only accept falls once real input has been seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      if (flush_cnt != FLUSH_N) flush_cnt <= flush_cnt + 3'd1;
      if (flush_cnt == FLUSH_N && load_s) armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign load_rise = load_s & ~load_d;
  assign load_fall = armed & load_d & ~load_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDL;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDL:     if (load_fall) state_n = SHF;
      SHF:     if (load_rise) state_n = IDL;
      default: state_n = IDL;
    endcase
  end

  always_comb begin
    busy      = (state == SHF);
    enter_shf = (state == IDL) && load_fall;
    latch     = (state == SHF) && load_rise;
    shift_en  = (state == SHF) && sclk_rise;
  end

  // A bit arriving in the same cycle as load rise is counted before the check.
  assign sh_nxt  = shift_en ? {shreg[14:0], sdi_s} : shreg;
  assign cnt_nxt = (shift_en && cnt != CNT_MAX) ? cnt + 5'd1 : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      pkt   <= '0;
      pcnt  <= '0;
      pvld  <= 1'b0;
      err   <= 1'b0;
    end else begin
      pvld <= 1'b0;
      err  <= 1'b0;
      if (enter_shf) begin
        shreg <= '0;
        cnt   <= '0;
      end else begin
        shreg <= sh_nxt;
        cnt   <= cnt_nxt;
      end
      if (latch) begin
        if (cnt_nxt == CNT_PKT) begin
          pkt  <= sh_nxt;
          pvld <= 1'b1;
          pcnt <= pcnt + 8'd1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_rcv.sv
// Scoreboard bench for pkt_rcv: directed frames push expected results, a
// negedge monitor pops and compares whenever pvld or err pulses.
module tb_pkt_rcv;

  localparam int SYNC_N = 2;
  localparam int HALF   = 4;
  localparam int GAP    = 2 * SYNC_N + 2;

  logic        clk = 1'b0;
  logic        rst, sclk, load, sdi;
  logic [15:0] pkt;
  logic        pvld, err, busy;
  logic [7:0]  pcnt;

  typedef struct {
    bit          is_err;
    logic [15:0] pkt;
    logic [7:0]  pcnt;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [15:0] exp_pkt  = '0;
  logic [7:0]  exp_pcnt = '0;

  pkt_rcv #(.SYNC_N(SYNC_N)) dut (
    .clk (clk),
    .rst (rst),
    .sclk(sclk),
    .load(load),
    .sdi (sdi),
    .pkt (pkt),
    .pvld(pvld),
    .err (err),
    .busy(busy),
    .pcnt(pcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_expect(input logic [31:0] val, input int nbits);
    exp_t e;
    if (nbits == 16) begin
      exp_pkt  = val[15:0];
      exp_pcnt = exp_pcnt + 8'd1;
      e.is_err = 1'b0;
    end else begin
      e.is_err = 1'b1;
    end
    e.pkt  = exp_pkt;
    e.pcnt = exp_pcnt;
    e.cyc  = cyc + 1 + SYNC_N;
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits,
                            input bit coinc, input bit raise);
    if (load == 1'b0) begin
      load = 1'b1;
      tick(GAP);
    end
    load = 1'b0;
    tick(SYNC_N + 3);
    check("busy_in_frame", busy, 1);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = val[i];
      tick(HALF);
      sclk = 1'b1;
      if (i == 0 && coinc) begin
        load = 1'b1;
        push_expect(val, nbits);
      end
      tick(HALF);
      sclk = 1'b0;
    end
    if (raise) begin
      if (!coinc) begin
        tick(HALF);
        load = 1'b1;
        push_expect(val, nbits);
      end
      tick(GAP);
      check("pulse_pending", q.size(), 0);
      check("busy_after", busy, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    exp_pkt  = '0;
    exp_pcnt = '0;
    check("rst_pkt", pkt, 0);
    check("rst_pcnt", pcnt, 0);
    check("rst_busy", busy, 0);
    check("rst_pvld", pvld, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick(4);
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (pvld && err) check("pvld_and_err", {pvld, err}, 2'b00);
      if (pvld || err) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", {pvld, err}, 2'b00);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pulse_kind_pvld", pvld, !e.is_err);
          check("pulse_kind_err", err, e.is_err);
          check("pulse_pkt", pkt, e.pkt);
          check("pulse_pcnt", pcnt, e.pcnt);
          check("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    load = 1'b1;
    sdi  = 1'b0;
    do_reset();

    send_frame(32'hA55A, 16, 1'b0, 1'b1);
    check("a55a_pkt", pkt, 16'hA55A);
    check("a55a_pcnt", pcnt, 8'd1);

    send_frame(32'h7ABC, 15, 1'b0, 1'b1);
    send_frame(32'h1F0F0, 17, 1'b0, 1'b1);
    check("bad_len_pkt", pkt, 16'hA55A);
    check("bad_len_pcnt", pcnt, 8'd1);

    send_frame(32'h0C01, 16, 1'b0, 1'b1);
    send_frame(32'h09FF, 16, 1'b0, 1'b1);
    check("b2b_pkt", pkt, 16'h09FF);
    check("b2b_pcnt", pcnt, 8'd3);

    // partial frame abandoned by reset, load kept low across reset release
    send_frame(32'h00C3, 8, 1'b0, 1'b0);
    tick(2);
    do_reset();
    tick(8);
    check("partial_busy", busy, 0);
    check("partial_pkt", pkt, 0);
    send_frame(32'h0F00, 16, 1'b0, 1'b1);
    check("after_rst_pkt", pkt, 16'h0F00);
    check("after_rst_pcnt", pcnt, 8'd1);

    send_frame(32'h1234, 16, 1'b1, 1'b1);
    check("coinc_pkt", pkt, 16'h1234);

    send_frame(32'h0, 0, 1'b0, 1'b1);
    check("zero_bits_pkt", pkt, 16'h1234);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = (i * 32'h0101) ^ 32'h5A00;
      send_frame(v, 16, 1'b0, 1'b1);
    end
    check("wrap_pcnt", pcnt, 8'h00);
    check("wrap_pkt", pkt, 16'hFFFF ^ 16'h5A00);

    tick(20);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
